// File: rtl/mem_pkg.sv
// Shared encodings for the byte-addressed data memory: access sizes, FSM states,
// wait-state counter width and a size-to-byte-count helper.
package mem_pkg;

  localparam int CNT_W = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // SIZE=11 behaves as a word.
  function automatic int size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_bytes = 1;
      SZ_HALF: size_bytes = 2;
      default: size_bytes = 4;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_array.sv
// DEPTH x 8 byte storage. Each lane has its own address; reads are combinational
// and writes are synchronous. Contents are never reset.
module mem_byte_array #(
  parameter int ADDR_W = 8,
  parameter int LANES  = 4
) (
  input  logic                          CLK,
  input  logic [LANES-1:0]              we,
  input  logic [LANES-1:0][ADDR_W-1:0]  addr,
  input  logic [LANES-1:0][7:0]         wdata,
  output logic [LANES-1:0][7:0]         rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [7:0] memory [DEPTH];

  // Lane addresses within one access are distinct, so lane writes never collide.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < LANES; i++) begin
      if (we[i]) memory[addr[i]] <= wdata[i];
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      rdata[i] = memory[addr[i]];
    end
  end

endmodule

// File: rtl/ram_moc_ctrl.sv
// Data memory with MFA/MOC handshake, programmable wait states, big-endian
// byte/half/word access and an idle-time byte loader. RAM_ALIGN_CHECK_EN adds ALIGN_ERR.
module ram_moc_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              MFA,
  input  logic              RW,
  input  logic [1:0]        SIZE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [31:0]       DATA_IN,
  output logic [31:0]       DATA_OUT,
  output logic              MOC,
  input  logic              LD_EN,
  input  logic [ADDR_W-1:0] LD_ADDR,
  input  logic [7:0]        LD_DATA,
`ifdef RAM_ALIGN_CHECK_EN
  output logic              ALIGN_ERR,
`endif
  output logic [1:0]        dbg_state
);

  localparam int NL = 4;

  // Handshake: the CU raises MFA and holds it; the request is accepted on the first
  // edge MFA is seen in IDLE. MOC stays high in DONE until MFA is seen low.
  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              rw_q;
  logic [31:0]       din_q;

  logic              accept, access, load;
  logic [ADDR_W-1:0] a_addr;
  logic [1:0]        a_size;
  logic              a_rw;
  logic [31:0]       a_din, din_al, rd_al;
  logic              misaligned;
  int                nb;

  logic [NL-1:0]             lane_we;
  logic [NL-1:0][ADDR_W-1:0] lane_addr;
  logic [NL-1:0][7:0]        lane_wdata, lane_rdata;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    access   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (MFA) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            access   = 1'b1;
            state_nx = ST_DONE;
          end else begin
            cnt_nx   = CNT_W'(WAIT_STATES);
            state_nx = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_nx = cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          access   = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!MFA) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // With zero wait states the access happens on the accept edge, so use live inputs.
  assign a_addr = (state == ST_IDLE) ? ADDR    : addr_q;
  assign a_size = (state == ST_IDLE) ? SIZE    : size_q;
  assign a_rw   = (state == ST_IDLE) ? RW      : rw_q;
  assign a_din  = (state == ST_IDLE) ? DATA_IN : din_q;
  assign load   = (state == ST_IDLE) && !MFA && LD_EN;

`ifdef RAM_ALIGN_CHECK_EN
  assign misaligned = ((a_size == SZ_HALF) && a_addr[0]) ||
                      (a_size[1] && (a_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Left-justify write data so lane 0 always carries the most significant byte used.
  always_comb begin
    nb     = size_bytes(a_size);
    din_al = a_din << (8 * (4 - nb));
    for (int i = 0; i < NL; i++) begin
      lane_addr[i]  = a_addr + ADDR_W'(i);
      lane_we[i]    = access && !a_rw && !misaligned && (i < nb);
      lane_wdata[i] = din_al[8*(3-i) +: 8];
    end
    if (load) begin
      lane_addr[0]  = LD_ADDR;
      lane_we[0]    = 1'b1;
      lane_wdata[0] = LD_DATA;
    end
    rd_al = {lane_rdata[0], lane_rdata[1], lane_rdata[2], lane_rdata[3]} >> (8 * (4 - nb));
  end

  mem_byte_array #(
    .ADDR_W (ADDR_W),
    .LANES  (NL)
  ) mem_byte_array (
    .CLK   (CLK),
    .we    (lane_we),
    .addr  (lane_addr),
    .wdata (lane_wdata),
    .rdata (lane_rdata)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      rw_q     <= 1'b0;
      din_q    <= '0;
      DATA_OUT <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        addr_q <= ADDR;
        size_q <= SIZE;
        rw_q   <= RW;
        din_q  <= DATA_IN;
      end
      if (access) begin
        if (misaligned)  DATA_OUT <= '0;
        else if (a_rw)   DATA_OUT <= rd_al;
      end
    end
  end

`ifdef RAM_ALIGN_CHECK_EN
  logic err_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)      err_q <= 1'b0;
    else if (access) err_q <= misaligned;
  end

  assign ALIGN_ERR = MOC && err_q;
`endif

  assign MOC       = (state == ST_DONE);
  assign dbg_state = state;

endmodule
